// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder sequencer for the M-extension.
// Produces one quotient bit per cycle and stalls the pipeline while it works.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_25mhz,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, busy_d;

  logic              sgn_a, sgn_b;
  logic [XLEN:0]     rem_ext, diff;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? (~v + 1'b1) : v;
  endfunction

  // Sign flags only exist for the signed ops (op_i[0] == 0).
  assign sgn_a   = ~op_i[0] & operand1_i[XLEN-1];
  assign sgn_b   = ~op_i[0] & operand2_i[XLEN-1];

  // The shifted-in partial remainder can be XLEN+1 bits wide; bit XLEN of diff is the borrow.
  assign rem_ext = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_ext - {1'b0, dvs_q};

  always_ff @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          sel_rem_d = op_i[1];
          neg_quo_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          if (operand2_i == '0) begin
            res_d   = op_i[1] ? operand1_i : '1;
            state_d = DONE;
          end else if (!op_i[0] && operand1_i == MIN_NEG && operand2_i == '1) begin
            res_d   = op_i[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            quo_d   = neg_if(sgn_a, operand1_i);
            dvs_d   = neg_if(sgn_b, operand2_i);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
          rem_d = diff[XLEN] ? rem_ext[XLEN-1:0] : diff[XLEN-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          res_d   = sel_rem_q ? neg_if(neg_rem_q, rem_q) : neg_if(neg_quo_q, quo_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d  = (state_d == CALC) || (state_d == FIX);

  assign stall_o = ((state_q == IDLE) && start_i && !flush_i) ||
                   (state_q == CALC) || (state_q == FIX);
  assign busy_o  = busy_q;
  assign done_o  = (state_q == DONE) && !flush_i;
  assign res_o   = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: countdown-based behavioural model with plain-arithmetic
// reference results, per-cycle compare, directed literal cases and random traffic.
module tb_div_sequencer;

  logic        clk_25mhz = 1'b0;
  logic        rst_n_i;
  logic        start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] operand1_i, operand2_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] res_o;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  div_sequencer #(.XLEN(32)) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .operand1_i(operand1_i),
    .operand2_i(operand2_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .res_o     (res_o)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  // Reference result straight from the RISC-V divide rules.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'(sx / sy);
      2'd1:    return x / y;
      2'd2:    return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // m_cnt = cycles until the done cycle: 0 idle, 1 done cycle, >=2 working.
  int          m_cnt;
  logic [31:0] m_res, m_pend;

  always @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_cnt  <= 0;
      m_res  <= 32'd0;
      m_pend <= 32'd0;
    end else if (m_cnt == 0) begin
      if (start_i && !flush_i) begin
        if (is_special(op_i, operand1_i, operand2_i)) begin
          m_cnt <= 1;
          m_res <= ref_res(op_i, operand1_i, operand2_i);
        end else begin
          m_cnt  <= 34;
          m_pend <= ref_res(op_i, operand1_i, operand2_i);
        end
      end
    end else if (m_cnt >= 2 && flush_i) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_res <= m_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk_25mhz);
    #3;
    if (chk_en) begin
      chk("stall", 32'(stall_o), 32'((m_cnt == 0 && start_i && !flush_i) || m_cnt >= 2));
      chk("busy",  32'(busy_o),  32'(m_cnt >= 2));
      chk("done",  32'(done_o),  32'(m_cnt == 1 && !flush_i));
      chk("res",   res_o,        m_res);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk_25mhz);
    start_i    = 1'b1;
    op_i       = o;
    operand1_i = x;
    operand2_i = y;
    @(negedge clk_25mhz);
    start_i    = 1'b0;
  endtask

  // Latency i means done_o is sampled at the i-th edge after the accepting edge.
  task automatic wait_done(input string nm, input logic [31:0] exp, input int exp_lat);
    int got;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      #4;
      if (done_o === 1'b1) begin
        got = i;
        break;
      end
      @(negedge clk_25mhz);
    end
    chk({nm, "_lat"}, 32'(got), 32'(exp_lat));
    chk({nm, "_res"}, res_o, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      4:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;

  initial begin
    rst_n_i    = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = 2'd0;
    operand1_i = 32'd0;
    operand2_i = 32'd0;
    chk_en     = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    #4;
    chk("rst_res",   res_o,          32'd0);
    chk("rst_busy",  32'(busy_o),    32'd0);
    chk("rst_stall", 32'(stall_o),   32'd0);
    chk("rst_done",  32'(done_o),    32'd0);
    @(negedge clk_25mhz);
    rst_n_i = 1'b1;

    issue(2'd1, 32'd100, 32'd7);               wait_done("divu_100_7", 32'd14, 34);
    issue(2'd3, 32'd100, 32'd7);               wait_done("remu_100_7", 32'd2, 34);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2);         wait_done("div_m7_2", 32'hFFFF_FFFD, 34);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);         wait_done("rem_m7_2", 32'hFFFF_FFFF, 34);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE);         wait_done("rem_7_m2", 32'd1, 34);
    issue(2'd0, 32'd123, 32'd0);               wait_done("div_by0", 32'hFFFF_FFFF, 1);
    issue(2'd3, 32'd5, 32'd0);                 wait_done("remu_by0", 32'd5, 1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", 32'h8000_0000, 1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem_ovf", 32'd0, 1);
    issue(2'd1, 32'h8000_0000, 32'd3);         wait_done("divu_big", 32'h2AAA_AAAA, 34);

    // Flush mid-calculation, then recover with a fresh request.
    held = res_o;
    issue(2'd1, 32'd1000, 32'd3);
    repeat (9) @(negedge clk_25mhz);
    flush_i = 1'b1;
    @(negedge clk_25mhz);
    flush_i = 1'b0;
    #4;
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_busy",  32'(busy_o),  32'd0);
    chk("flush_done",  32'(done_o),  32'd0);
    chk("flush_res",   res_o,        held);
    issue(2'd1, 32'd9, 32'd3);                 wait_done("divu_9_3", 32'd3, 34);

    // Requests presented while busy must be ignored.
    issue(2'd1, 32'd5000, 32'd7);
    repeat (5) @(negedge clk_25mhz);
    for (int i = 0; i < 10; i++) begin
      start_i    = 1'($urandom);
      op_i       = 2'($urandom);
      operand1_i = $urandom;
      operand2_i = $urandom;
      @(negedge clk_25mhz);
    end
    start_i = 1'b0;
    wait_done("ignored_start", 32'd714, 19);

    // Asynchronous reset in the middle of a calculation.
    issue(2'd1, 32'd1000, 32'd3);
    repeat (20) @(negedge clk_25mhz);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_res",   res_o,        32'd0);
    chk("arst_busy",  32'(busy_o),  32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_done",  32'(done_o),  32'd0);
    @(negedge clk_25mhz);
    rst_n_i = 1'b1;
    issue(2'd2, 32'hFFFF_FF9C, 32'd7);         wait_done("rem_m100_7", 32'hFFFF_FFFE, 34);

    // Random traffic: the per-cycle compare carries the checking.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk_25mhz);
      start_i    = ($urandom % 4) == 0;
      op_i       = 2'($urandom);
      operand1_i = pick();
      operand2_i = pick();
      flush_i    = ($urandom % 40) == 0;
      if (($urandom % 1500) == 0) begin
        start_i = 1'b0;
        flush_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #4 rst_n_i = 1'b1;
      end
    end
    @(negedge clk_25mhz);
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(negedge clk_25mhz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
